imm_encoder: RTL and testbench
==============================

# imm_encoder

Streaming immediate packer: the inverse of the immediate extender. Takes a 32-bit immediate value plus an instruction template and scatters the immediate bits into the RV32I I/S/B/J/U field positions, producing the encoded instruction word. Range-checks the immediate for the chosen format. Sits in front of the instruction-memory loader and the self-test instruction generator, behind a two-stage valid/ready pipeline.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept the request this cycle.
- `in_immsrc` in 3: format. 000 I, 001 S, 010 B, 011 J, 100 U; 101–111 undefined.
- `in_imm` in 32: immediate value, as the extender would output it.
- `in_base` in 32: instruction template (opcode, rd, rs1, rs2, funct). Bits at immediate positions are overwritten.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_instr` out 32: encoded instruction.
- `out_err` out 1: immediate not representable in the format, or `in_immsrc` undefined. Qualified by `out_valid`.
- `err_count` out 16: saturating count of results delivered with `out_err`=1.

## Operation
- **Packing.** Bits not listed below come from `in_base`.
  - I: instr[31:20]=imm[11:0].
  - S: [31:25]=imm[11:5]; [11:7]=imm[4:0].
  - B: [31]=imm[12]; [30:25]=imm[10:5]; [11:8]=imm[4:1]; [7]=imm[11].
  - J: [31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
  - Undefined format: `out_instr`=`in_base` unchanged.
- **Representability** (requires `IMM_ENC_CHECK_EN`).
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal, and imm[0]=0.
  - J: imm[31:20] all equal, and imm[0]=0.
  - U: imm[11:0]=0.
  - On failure the truncated encoding is still emitted, with `out_err`=1.
- **Round-trip property.** Whenever `out_err`=0, extending `out_instr` with the same format returns `in_imm` exactly.
- **Pipeline.**
  - Stage 1 registers the request: immsrc, imm, base.
  - Stage 2 registers the packed word, the error flag and the valid bit.
  - Packing and checking are combinational between the stages.
- **Handshake.**
  - A transfer happens when valid and ready are both 1 on a rising edge.
  - `in_ready` = !s1_valid || !out_valid || out_ready. It is combinational from `out_ready`.
  - Stage 2 loads when s1_valid && (!out_valid || out_ready).
  - Once raised, `out_valid` and `out_instr` stay stable until accepted.
- **err_count.**
  - Increments on each output transfer with `out_err`=1.
  - Saturates at 16'hFFFF.

## Timing
- **Reset** (`reset_n`=0 at a rising edge):
  - s1_valid=0, `out_valid`=0, `out_instr`=0, `out_err`=0, `err_count`=0.
  - `in_ready` reads 1 in the first cycle after reset.
  - In-flight requests are discarded.
- **Latency.** A request accepted at edge N appears with `out_valid`=1 after edge N+1 (2-register path), provided stage 2 is free.
- **Throughput.** One result per cycle while `out_ready`=1.
- **Backpressure.**
  - With `out_ready`=0 the pipeline holds two requests.
  - With both stages full, `in_ready` follows `out_ready` combinationally.
- **Simultaneous events.**
  - Output accept, stage-2 refill and input accept may all occur on the same edge. No bubble, no loss.
  - Reset asserted in the same cycle as a handshake wins; the transfer is dropped.

## Configuration
- `IMM_ENC_CHECK_EN` defined:
  - Range checking as above.
  - Undefined `in_immsrc` sets `out_err`=1.
  - `err_count` is active.
- `IMM_ENC_CHECK_EN` undefined:
  - No check logic.
  - `out_err` is tied to 0 and `err_count` to 0.
  - Packing and timing are unchanged.

## Test plan
- **I-type.** immsrc=000, imm=32'hFFFFF800, base=32'h00000013, single request with `out_ready`=1.
  - `out_instr`=32'h80000013, `out_err`=0, after 2 edges.
- **B-type and J-type.**
  - B: immsrc=010, imm=32'hFFFFFFFE, base=32'h00000063 → `out_instr`=32'hFE000FE3, err=0.
  - J: immsrc=011, imm=32'h00000800, base=32'h0000006F → `out_instr`=32'h0010006F.
- **Range errors** (with `IMM_ENC_CHECK_EN`).
  - I imm=32'h00000800 → err=1, `out_instr`[31:20]=12'h800.
  - B imm=32'h00000003 → err=1.
  - U imm=32'h12345001 → err=1, [31:12]=20'h12345.
  - immsrc=110 → instr=base, err=1.
  - `err_count`=4 afterwards.
- **Backpressure.** Hold `out_ready`=0 and drive 3 back-to-back requests.
  - Exactly 2 are accepted; `in_ready`=0 on the third.
  - Raise `out_ready`: results emerge in order, one per cycle, and the third is then accepted.
- **Reset mid-stream.** Both stages full; drive `reset_n`=0 for one edge.
  - `out_valid`=0, `err_count`=0, `in_ready`=1.
  - The next request emerges with its own data only.
- **Randomized round-trip.** Random formats and representable immediates, random `out_ready`.
  - Extending each `out_instr` with the same format equals the source imm; `out_err`=0 throughout.

Source files
------------

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/result handshake bundle for imm_encoder.
// The master side drives requests and accepts results; the slave side is the encoder.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_immsrc;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_immsrc, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_immsrc, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: scatters a 32-bit immediate into the RV32I I/S/B/J/U field
// positions of an instruction template, behind a two-stage valid/ready pipe.
// Build option: define IMM_ENC_CHECK_EN to enable range checking, out_err and
// the saturating err_count; without it out_err and err_count read as zero.
module imm_encoder (
  input  logic            clk,
  input  logic            reset_n,
  imm_encoder_if.slave    bus,
  output logic [15:0]     err_count
);

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100
  } fmt_e;

  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_immsrc_q, s1_immsrc_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic [31:0] s1_base_q, s1_base_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;

  logic        in_fire;
  logic        s2_load;
  logic        out_fire;
  logic [31:0] packed_instr;

  // Stage 1 can take a request when it is empty or will drain into stage 2 this edge.
  assign bus.in_ready  = !s1_valid_q || !out_valid_q || bus.out_ready;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign s2_load       = s1_valid_q && (!out_valid_q || bus.out_ready);
  assign out_fire      = out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;

  // Stage 1 next state: capture a new request, or empty once its word moves on.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_immsrc_d = s1_immsrc_q;
    s1_imm_d    = s1_imm_q;
    s1_base_d   = s1_base_q;
    if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_immsrc_d = bus.in_immsrc;
      s1_imm_d    = bus.in_imm;
      s1_base_d   = bus.in_base;
    end else if (s2_load) begin
      s1_valid_d  = 1'b0;
    end
  end

  // Stage 1 registers; reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_immsrc_q <= 3'b000;
      s1_imm_q    <= 32'h0;
      s1_base_q   <= 32'h0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_immsrc_q <= s1_immsrc_d;
      s1_imm_q    <= s1_imm_d;
      s1_base_q   <= s1_base_d;
    end
  end

  // Scatter immediate bits into the format's field positions over the template.
  always_comb begin
    packed_instr = s1_base_q;
    case (s1_immsrc_q)
      FMT_I: packed_instr[31:20] = s1_imm_q[11:0];
      FMT_S: begin
        packed_instr[31:25] = s1_imm_q[11:5];
        packed_instr[11:7]  = s1_imm_q[4:0];
      end
      FMT_B: begin
        packed_instr[31]    = s1_imm_q[12];
        packed_instr[30:25] = s1_imm_q[10:5];
        packed_instr[11:8]  = s1_imm_q[4:1];
        packed_instr[7]     = s1_imm_q[11];
      end
      FMT_J: begin
        packed_instr[31]    = s1_imm_q[20];
        packed_instr[30:21] = s1_imm_q[10:1];
        packed_instr[20]    = s1_imm_q[11];
        packed_instr[19:12] = s1_imm_q[19:12];
      end
      FMT_U: packed_instr[31:12] = s1_imm_q[31:12];
      default: packed_instr = s1_base_q;
    endcase
  end

  // Stage 2 next state: load the packed word, or go empty after the result is taken.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_instr_d = packed_instr;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
    end
  end

`ifdef IMM_ENC_CHECK_EN
  logic        range_err;
  logic        out_err_q, out_err_d;
  logic [15:0] err_count_q, err_count_d;

  // Flag immediates whose dropped bits are not a pure sign extension (or low bits set).
  always_comb begin
    range_err = 1'b0;
    case (s1_immsrc_q)
      FMT_I, FMT_S: range_err = !(&s1_imm_q[31:11] || ~|s1_imm_q[31:11]);
      FMT_B:        range_err = !(&s1_imm_q[31:12] || ~|s1_imm_q[31:12]) || s1_imm_q[0];
      FMT_J:        range_err = !(&s1_imm_q[31:20] || ~|s1_imm_q[31:20]) || s1_imm_q[0];
      FMT_U:        range_err = |s1_imm_q[11:0];
      default:      range_err = 1'b1;
    endcase
  end

  // Error flag travels with the packed word; the counter sticks at all-ones.
  always_comb begin
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    if (s2_load) begin
      out_err_d = range_err;
    end
    if (out_fire && out_err_q && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Error flag and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_err_q   <= 1'b0;
      err_count_q <= 16'h0;
    end else begin
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_err = out_err_q;
  assign err_count   = err_count_q;
`else
  assign bus.out_err = 1'b0;
  assign err_count   = 16'h0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench for imm_encoder. Expected words are built
// from an independent concatenation model when a request is accepted and
// compared when the result is accepted. Error expectations follow IMM_ENC_CHECK_EN.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] err_count;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
    logic        repr;
  } exp_t;

  exp_t sbQ[$];
  int   totalChecks = 0;
  int   badChecks   = 0;
  int   expErrCount = 0;
  bit   randomReady = 1'b0;

  // Reference decoder: what the immediate extender recovers from an instruction.
  function automatic logic [31:0] extendImm(input logic [2:0] fmt, input logic [31:0] ins);
    case (fmt)
      3'd0: return {{20{ins[31]}}, ins[31:20]};
      3'd1: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd4: return {ins[31:12], 12'h000};
      default: return 32'h0;
    endcase
  endfunction

  // Reference packer written as whole-word concatenations.
  function automatic logic [31:0] packModel(input logic [2:0] fmt, input logic [31:0] imm,
                                            input logic [31:0] base);
    case (fmt)
      3'd0: return {imm[11:0], base[19:0]};
      3'd1: return {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      3'd2: return {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      3'd3: return {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
      3'd4: return {imm[31:12], base[11:0]};
      default: return base;
    endcase
  endfunction

  // Representable means packing then extending gives the immediate back.
  function automatic logic reprModel(input logic [2:0] fmt, input logic [31:0] imm);
    return (fmt <= 3'd4) && (extendImm(fmt, packModel(fmt, imm, 32'h0)) == imm);
  endfunction

  function automatic logic errModel(input logic repr);
`ifdef IMM_ENC_CHECK_EN
    return !repr;
`else
    return repr & 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples handshakes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbQ.size() == 0) begin
          checkOutput("spurious_out", 32'(sbQ.size()), 32'd1);
        end else begin
          e = sbQ.pop_front();
          checkOutput("instr", bus.out_instr, e.instr);
          checkOutput("err", {31'b0, bus.out_err}, {31'b0, e.err});
          if (e.repr) checkOutput("roundtrip", extendImm(e.fmt, bus.out_instr), e.imm);
          if (e.err && expErrCount < 65535) expErrCount++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.fmt   = bus.in_immsrc;
        e.imm   = bus.in_imm;
        e.instr = packModel(bus.in_immsrc, bus.in_imm, bus.in_base);
        e.repr  = reprModel(bus.in_immsrc, bus.in_imm);
        e.err   = errModel(e.repr);
        sbQ.push_back(e);
      end
    end
  end

  // Wait (bounded) until the request currently driven is accepted.
  task automatic waitAccept();
    int tries = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      if (randomReady) bus.out_ready = 1'($urandom_range(0, 1));
      tries++;
      if (tries >= 200) begin
        checkOutput("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
        return;
      end
    end
  endtask

  task automatic applyStimulus(input logic [2:0] fmt, input logic [31:0] imm, input logic [31:0] base);
    bus.in_valid  = 1'b1;
    bus.in_immsrc = fmt;
    bus.in_imm    = imm;
    bus.in_base   = base;
    waitAccept();
  endtask

  task automatic drainPipe();
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sbQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    sbQ.delete();
    expErrCount = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] imm;
    logic [2:0]  fmt;

    bus.in_valid  = 1'b0;
    bus.in_immsrc = 3'b000;
    bus.in_imm    = 32'h0;
    bus.in_base   = 32'h0;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    @(posedge clk);
    #1;
    resetDut();

    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_instr", bus.out_instr, 32'h0);
    checkOutput("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // I-type with two-edge latency
    applyStimulus(3'b000, 32'hFFFFF800, 32'h00000013);
    bus.in_valid = 1'b0;
    checkOutput("lat_edge_n", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_edge_n1", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("i_type_word", bus.out_instr, 32'h80000013);
    @(posedge clk);
    #1;

    // B and J back to back
    applyStimulus(3'b010, 32'hFFFFFFFE, 32'h00000063);
    applyStimulus(3'b011, 32'h00000800, 32'h0000006F);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b_type_word", bus.out_instr, 32'hFE000FE3);
    @(negedge clk);
    checkOutput("j_type_word", bus.out_instr, 32'h0010006F);
    drainPipe();

    // Unrepresentable immediates and an undefined format
    applyStimulus(3'b000, 32'h00000800, 32'h00000013);
    applyStimulus(3'b010, 32'h00000003, 32'h00000063);
    applyStimulus(3'b100, 32'h12345001, 32'h00000037);
    applyStimulus(3'b110, 32'h0000ABCD, 32'h12345678);
    applyStimulus(3'b001, 32'hFFFFF801, 32'h00000023);
    drainPipe();
    checkOutput("err_count_model", 32'(err_count), 32'(expErrCount));
`ifdef IMM_ENC_CHECK_EN
    checkOutput("err_count_four", 32'(err_count), 32'd4);
`endif

    // Backpressure: two requests fill the pipe, the third waits
    bus.out_ready = 1'b0;
    applyStimulus(3'b001, 32'h000007FF, 32'h00000023);
    applyStimulus(3'b100, 32'hABCDE000, 32'h00000037);
    bus.in_valid  = 1'b1;
    bus.in_immsrc = 3'b000;
    bus.in_imm    = 32'h00000005;
    bus.in_base   = 32'h00000013;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("bp_accepted_two", 32'(sbQ.size()), 32'd2);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_follows", {31'b0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_one_per_cycle", {31'b0, bus.out_valid}, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
    checkOutput("bp_drained", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("bp_sb_empty", 32'(sbQ.size()), 32'd0);

    // Reset with both stages full and a request on the input
    bus.out_ready = 1'b0;
    applyStimulus(3'b000, 32'h00000123, 32'h00000013);
    applyStimulus(3'b001, 32'h00000456, 32'h00000023);
    bus.in_immsrc = 3'b100;
    bus.in_imm    = 32'hDEAD0000;
    bus.in_base   = 32'h00000037;
    bus.in_valid  = 1'b1;
    resetDut();
    bus.in_valid  = 1'b0;
    checkOutput("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("mid_rst_err_count", 32'(err_count), 32'd0);
    checkOutput("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    applyStimulus(3'b011, 32'hFFF00000, 32'h0000006F);
    drainPipe();

    // Randomized round trip with representable immediates
    randomReady = 1'b1;
    for (int i = 0; i < 60; i++) begin
      fmt = 3'($urandom_range(0, 4));
      r   = $urandom;
      case (fmt)
        3'd0, 3'd1: imm = {{20{r[11]}}, r[11:0]};
        3'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
        3'd3:       imm = {{11{r[20]}}, r[20:1], 1'b0};
        default:    imm = {r[31:12], 12'h000};
      endcase
      bus.out_ready = 1'($urandom_range(0, 1));
      applyStimulus(fmt, imm, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    randomReady = 1'b0;
    drainPipe();
    checkOutput("final_err_count", 32'(err_count), 32'(expErrCount));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
